branch_target_predictor: RTL and testbench

Parametrised branch target buffer with a 2-bit saturating direction counter per entry, for the 5-stage pipelined datapath. The IF stage looks up the fetch PC in the same cycle and gets a predicted next PC. The ID stage writes back resolved branch and jump outcomes, which replaces the current "always not-taken, flush on resolve" policy with learned prediction. It also keeps performance counters for lookups, hits and updates.

---
 rtl/branch_target_predictor.sv | 124 ++++++++++++
 tb/tb_branch_target_predictor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Zero-latency lookup for IF; registered update from ID-stage resolution; performance counters.
module branch_target_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned PC_W     = 32,
  parameter logic [1:0]  INIT_CTR = 2'b01,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lookup_en,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              update_en,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              update_taken,
  input  logic              update_is_branch,
  input  logic [PC_W-1:0]   update_target,
  input  logic              flush_all,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_updates
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [STAT_W-1:0] stat_lookups_q, stat_hits_q, stat_updates_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  // Instruction-aligned PCs: the byte-offset bits never participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[PC_W-1:IDX_W+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : '0;
  end

  // Next state for the single entry addressed by the update port.
  logic            up_write;
  logic            up_write_target;
  logic [1:0]      up_ctr_d;

  always_comb begin
    up_write        = 1'b0;
    up_write_target = 1'b0;
    up_ctr_d        = ctr_q[up_idx];
    if (up_hit) begin
      up_write = 1'b1;
      if (update_is_branch) begin
        up_write_target = update_taken;
        if (update_taken) begin
          if (up_ctr_d != 2'b11) up_ctr_d = up_ctr_d + 2'b01;
        end else begin
          if (up_ctr_d != 2'b00) up_ctr_d = up_ctr_d - 2'b01;
        end
      end else begin
        up_write_target = 1'b1;
        up_ctr_d        = 2'b11;
      end
    end else if (update_taken) begin
      // Allocation overwrites whatever aliasing entry sits at this index.
      up_write        = 1'b1;
      up_write_target = 1'b1;
      up_ctr_d        = update_is_branch ? 2'b10 : 2'b11;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= INIT_CTR;
      end
    end else if (flush_all) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= INIT_CTR;
      end
    end else if (update_en && up_write) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      ctr_q[up_idx]   <= up_ctr_d;
      if (up_write_target) target_q[up_idx] <= update_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
      stat_updates_q <= '0;
    end else begin
      if (lookup_en)              stat_lookups_q <= stat_lookups_q + STAT_W'(1);
      if (lookup_en && pred_taken) stat_hits_q   <= stat_hits_q + STAT_W'(1);
      if (update_en && !flush_all) stat_updates_q <= stat_updates_q + STAT_W'(1);
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
  assign stat_updates = stat_updates_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: vector table for training/aliasing,
// hand-written sequences for same-cycle, flush, reset and counter-wrap cases.
module tb_branch_target_predictor;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned STAT_W = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              lookup_en;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              update_en;
  logic [PC_W-1:0]   update_pc;
  logic              update_taken;
  logic              update_is_branch;
  logic [PC_W-1:0]   update_target;
  logic              flush_all;
  logic [STAT_W-1:0] stat_lookups, stat_hits, stat_updates;

  branch_target_predictor #(
    .ENTRIES (16),
    .PC_W    (PC_W),
    .INIT_CTR(2'b01),
    .STAT_W  (STAT_W)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .lookup_en       (lookup_en),
    .lookup_pc       (lookup_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .update_en       (update_en),
    .update_pc       (update_pc),
    .update_taken    (update_taken),
    .update_is_branch(update_is_branch),
    .update_target   (update_target),
    .flush_all       (flush_all),
    .stat_lookups    (stat_lookups),
    .stat_hits       (stat_hits),
    .stat_updates    (stat_updates)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        upd;
    logic [31:0] pc;
    logic        taken;
    logic        is_br;
    logic [31:0] tgt;
    logic [31:0] lk;
    logic        exp_t;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[16];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic u, logic [31:0] pc, logic t, logic b, logic [31:0] tg,
                              logic [31:0] lk, logic et, logic [31:0] etg);
    vec_t v;
    v.upd = u; v.pc = pc; v.taken = t; v.is_br = b; v.tgt = tg;
    v.lk = lk; v.exp_t = et; v.exp_tgt = etg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; update_en = 1'b0; flush_all = 1'b0; lookup_en = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic t, input logic b,
                           input logic [31:0] tg);
    update_en = 1'b1; update_pc = pc; update_taken = t; update_is_branch = b;
    update_target = tg;
  endtask

  initial begin
    RST = 1'b1; lookup_en = 1'b0; lookup_pc = '0; update_en = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_is_branch = 1'b0; update_target = '0; flush_all = 1'b0;

    // 0x40/0x80/0xC0 share index 0 (tags 1/2/3); 0x84/0xC4 share index 1.
    vecs[0]  = mk(0, 32'h00, 0, 0, 32'h000, 32'h40, 0, 32'h000);
    vecs[1]  = mk(1, 32'h40, 1, 1, 32'h100, 32'h40, 1, 32'h100);
    vecs[2]  = mk(1, 32'h40, 0, 1, 32'h300, 32'h40, 0, 32'h000);
    vecs[3]  = mk(1, 32'h40, 1, 1, 32'h100, 32'h40, 1, 32'h100);
    vecs[4]  = mk(1, 32'h40, 1, 1, 32'h100, 32'h40, 1, 32'h100);
    vecs[5]  = mk(1, 32'h40, 1, 1, 32'h100, 32'h40, 1, 32'h100);
    vecs[6]  = mk(1, 32'h40, 1, 1, 32'h100, 32'h40, 1, 32'h100);
    vecs[7]  = mk(1, 32'h40, 0, 1, 32'h300, 32'h40, 1, 32'h100);
    vecs[8]  = mk(0, 32'h00, 0, 0, 32'h000, 32'h80, 0, 32'h000);
    vecs[9]  = mk(1, 32'h80, 1, 0, 32'h200, 32'h80, 1, 32'h200);
    vecs[10] = mk(0, 32'h00, 0, 0, 32'h000, 32'h40, 0, 32'h000);
    vecs[11] = mk(1, 32'h80, 0, 1, 32'h500, 32'h80, 1, 32'h200);
    vecs[12] = mk(1, 32'hC4, 0, 1, 32'h044, 32'hC4, 0, 32'h000);
    vecs[13] = mk(1, 32'hC4, 1, 1, 32'h044, 32'hC4, 1, 32'h044);
    vecs[14] = mk(1, 32'h84, 0, 1, 32'h777, 32'hC4, 1, 32'h044);
    vecs[15] = mk(0, 32'h00, 0, 0, 32'h000, 32'hC7, 1, 32'h044);

    do_reset();
    lookup_pc = 32'h40;
    #1;
    chk("reset pred_taken", {31'b0, pred_taken}, 32'h0);
    chk("reset pred_target", pred_target, 32'h0);
    chk("reset stat_lookups", {28'b0, stat_lookups}, 32'h0);
    chk("reset stat_hits", {28'b0, stat_hits}, 32'h0);
    chk("reset stat_updates", {28'b0, stat_updates}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      update_en = vecs[i].upd; update_pc = vecs[i].pc; update_taken = vecs[i].taken;
      update_is_branch = vecs[i].is_br; update_target = vecs[i].tgt;
      lookup_pc = vecs[i].lk;
      tick();
      update_en = 1'b0;
      #1;
      chk($sformatf("vec%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].exp_t});
      chk($sformatf("vec%0d pred_target", i), pred_target, vecs[i].exp_tgt);
    end

    // Same-cycle update and lookup: no bypass.
    do_reset();
    drive_upd(32'h40, 1'b1, 1'b1, 32'h100);
    lookup_pc = 32'h40;
    #1;
    chk("samecycle pre pred_taken", {31'b0, pred_taken}, 32'h0);
    tick();
    update_en = 1'b0;
    #1;
    chk("samecycle post pred_taken", {31'b0, pred_taken}, 32'h1);
    chk("samecycle post pred_target", pred_target, 32'h100);
    chk("samecycle stat_updates", {28'b0, stat_updates}, 32'h1);

    // Flush beats a same-cycle update, which is not counted.
    drive_upd(32'hC0, 1'b1, 1'b0, 32'h600);
    flush_all = 1'b1;
    tick();
    update_en = 1'b0; flush_all = 1'b0;
    lookup_pc = 32'h40;
    #1;
    chk("flush miss 0x40", {31'b0, pred_taken}, 32'h0);
    lookup_pc = 32'hC0;
    #1;
    chk("flush miss 0xC0", {31'b0, pred_taken}, 32'h0);
    chk("flush stat_updates", {28'b0, stat_updates}, 32'h1);

    // Reset beats a same-cycle update.
    drive_upd(32'h40, 1'b1, 1'b1, 32'h100);
    tick();
    update_en = 1'b0;
    drive_upd(32'h80, 1'b1, 1'b0, 32'h200);
    RST = 1'b1;
    tick();
    RST = 1'b0; update_en = 1'b0;
    lookup_pc = 32'h80;
    #1;
    chk("rst drops update", {31'b0, pred_taken}, 32'h0);
    lookup_pc = 32'h40;
    #1;
    chk("rst clears entry", {31'b0, pred_taken}, 32'h0);
    chk("rst stat_updates", {28'b0, stat_updates}, 32'h0);

    // Stat counters: 17 lookups wrap a 4-bit counter to 1; gated lookups are ignored.
    drive_upd(32'h40, 1'b1, 1'b1, 32'h100);
    tick();
    update_en = 1'b0;
    lookup_pc = 32'h40;
    lookup_en = 1'b1;
    repeat (17) tick();
    lookup_en = 1'b0;
    #1;
    chk("wrap stat_lookups", {28'b0, stat_lookups}, 32'h1);
    chk("wrap stat_hits", {28'b0, stat_hits}, 32'h1);
    repeat (3) tick();
    chk("gated stat_lookups", {28'b0, stat_lookups}, 32'h1);
    chk("gated stat_hits", {28'b0, stat_hits}, 32'h1);
    lookup_pc = 32'h80;
    lookup_en = 1'b1;
    tick();
    lookup_en = 1'b0;
    #1;
    chk("miss stat_lookups", {28'b0, stat_lookups}, 32'h2);
    chk("miss stat_hits", {28'b0, stat_hits}, 32'h1);
    chk("final stat_updates", {28'b0, stat_updates}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
